axi4_lite_simple_master: RTL and testbench

//  Single-outstanding AXI4-lite initiator. Converts a simple cmd/rsp handshake

---
 rtl/axi4_lite_simple_master_if.sv | 82 ++++++++
 rtl/axi4_lite_simple_master.sv | 205 ++++++++++++++++++++
 tb/tb_axi4_lite_simple_master.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_simple_master_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_if
// Brief    : AXI4 signal bundle with master/slave views, sized by A/N/I.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_if #(
    parameter int A = 32,
    parameter int N = 4,
    parameter int I = 1
) ();
    logic [I-1:0]   awid;
    logic [A-1:0]   awaddr;
    logic [7:0]     awlen;
    logic [2:0]     awsize;
    logic [1:0]     awburst;
    logic           awlock;
    logic [3:0]     awcache;
    logic [2:0]     awprot;
    logic [3:0]     awqos;
    logic [3:0]     awregion;
    logic           awvalid;
    logic           awready;

    logic [8*N-1:0] wdata;
    logic [N-1:0]   wstrb;
    logic           wlast;
    logic           wvalid;
    logic           wready;

    logic [I-1:0]   bid;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;

    logic [I-1:0]   arid;
    logic [A-1:0]   araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arlock;
    logic [3:0]     arcache;
    logic [2:0]     arprot;
    logic [3:0]     arqos;
    logic [3:0]     arregion;
    logic           arvalid;
    logic           arready;

    logic [I-1:0]   rid;
    logic [8*N-1:0] rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_simple_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_simple_master
// Brief    : Single-outstanding AXI4-lite initiator behind a cmd/rsp handshake.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_simple_master #(
    parameter int           A       = 32,
    parameter int           N       = 4,
    parameter int           I       = 1,
    parameter logic [I-1:0] ID      = '0,
    parameter int           TIMEOUT = 0
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_write,
    input  logic [A-1:0]   cmd_addr,
    input  logic [8*N-1:0] cmd_wdata,
    input  logic [N-1:0]   cmd_wstrb,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [8*N-1:0] rsp_rdata,
    output logic [1:0]     rsp_resp,
    output logic           rsp_timeout,
    axi4_if.master         axi4_m
);
    localparam int                 c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO   = c_CNT_W'(TIMEOUT);
    localparam logic [2:0]         c_SIZE  = 3'($clog2(N));

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RR, S_DONE} state_t;

    state_t             r_state;
    logic               r_cmd_ready;
    logic               r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
    logic               r_aw_done, r_w_done;
    logic [A-1:0]       r_addr;
    logic [8*N-1:0]     r_wdata;
    logic [N-1:0]       r_wstrb;
    logic               r_rsp_valid, r_rsp_timeout;
    logic [8*N-1:0]     r_rsp_rdata;
    logic [1:0]         r_rsp_resp;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_busy, w_tmo, w_rsp_hs, w_aw_fin, w_w_fin;
    logic [c_CNT_W-1:0] w_cnt_inc;

    assign w_busy    = (r_state == S_WR) || (r_state == S_WB) || (r_state == S_RA) || (r_state == S_RR);
    assign w_cnt_inc = r_cnt + c_CNT_W'(1);
    assign w_tmo     = (TIMEOUT > 0) && w_busy && (w_cnt_inc == c_TMO);
    assign w_rsp_hs  = ((r_state == S_WB) && axi4_m.bvalid) || ((r_state == S_RR) && axi4_m.rvalid);
    assign w_aw_fin  = r_aw_done || (r_awvalid && axi4_m.awready);
    assign w_w_fin   = r_w_done  || (r_wvalid  && axi4_m.wready);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_bready      <= 1'b0;
            r_rready      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_cnt         <= '0;
        end else begin
            if (w_busy && (r_cnt != c_TMO)) begin
                r_cnt <= w_cnt_inc;
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        r_cnt       <= '0;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        if (cmd_write) begin
                            r_state   <= S_WR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= S_RA;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    // AW and W complete independently; each valid drops after its own beat
                    if (r_awvalid && axi4_m.awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && axi4_m.wready) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_state  <= S_WB;
                        r_bready <= 1'b1;
                    end
                end
                S_WB: begin
                    if (axi4_m.bvalid) begin
                        r_bready      <= 1'b0;
                        r_rsp_resp    <= axi4_m.bresp;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_RA: begin
                    if (axi4_m.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RR;
                    end
                end
                S_RR: begin
                    if (axi4_m.rvalid) begin
                        r_rready      <= 1'b0;
                        r_rsp_resp    <= axi4_m.rresp;
                        r_rsp_rdata   <= axi4_m.rdata;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
            // Abort overrides the per-state updates; a response landing this cycle still wins
            if (w_tmo && !w_rsp_hs) begin
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_bready      <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_resp    <= 2'b10;
                r_rsp_rdata   <= '0;
                r_rsp_timeout <= 1'b1;
                r_rsp_valid   <= 1'b1;
                r_state       <= S_DONE;
            end
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;

    assign axi4_m.awid     = ID;
    assign axi4_m.awaddr   = r_addr;
    assign axi4_m.awlen    = 8'd0;
    assign axi4_m.awsize   = c_SIZE;
    assign axi4_m.awburst  = 2'b01;
    assign axi4_m.awlock   = 1'b0;
    assign axi4_m.awcache  = 4'd0;
    assign axi4_m.awprot   = 3'd0;
    assign axi4_m.awqos    = 4'd0;
    assign axi4_m.awregion = 4'd0;
    assign axi4_m.awvalid  = r_awvalid;
    assign axi4_m.wdata    = r_wdata;
    assign axi4_m.wstrb    = r_wstrb;
    assign axi4_m.wlast    = 1'b1;
    assign axi4_m.wvalid   = r_wvalid;
    assign axi4_m.bready   = r_bready;
    assign axi4_m.arid     = ID;
    assign axi4_m.araddr   = r_addr;
    assign axi4_m.arlen    = 8'd0;
    assign axi4_m.arsize   = c_SIZE;
    assign axi4_m.arburst  = 2'b01;
    assign axi4_m.arlock   = 1'b0;
    assign axi4_m.arcache  = 4'd0;
    assign axi4_m.arprot   = 3'd0;
    assign axi4_m.arqos    = 4'd0;
    assign axi4_m.arregion = 4'd0;
    assign axi4_m.arvalid  = r_arvalid;
    assign axi4_m.rready   = r_rready;
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_simple_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_simple_master
// Brief    : Directed plus randomized checks of the AXI4-lite initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_simple_master;
    localparam int A   = 32;
    localparam int N   = 4;
    localparam int I   = 1;
    localparam int TMO = 16;

    logic        aclk, areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    axi4_if #(.A(A), .N(N), .I(I)) axi ();

    axi4_lite_simple_master #(.A(A), .N(N), .I(I), .ID(1'b0), .TIMEOUT(TMO)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .rsp_timeout(rsp_timeout),
        .axi4_m     (axi)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_delay = 0, cfg_b_delay = 0, cfg_r_delay = 0;
    logic       cfg_ar_never = 1'b0;
    logic [1:0] cfg_resp = 2'b00;
    int cnt_aw = 0, cnt_w = 0, cnt_ar = 0, cnt_b = 0, cnt_r = 0, cnt_arv = 0;
    int e_aw = 0, e_w = 0, e_ar = 0, e_b = 0, e_r = 0;
    int aw_age = 0, w_age = 0, ar_age = 0, b_age = 0, r_age = 0;
    logic got_aw = 1'b0, got_w = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata, s_cur;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic [13:0] s_awfix, s_arfix;
    logic [31:0] smem [logic [31:0]];
    logic [31:0] exp_mem [logic [31:0]];
    int last_ta, last_tr;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        exp_mem[a] = (model_read(a) & ~mask) | (d & mask);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: samples handshakes at the edge, drives its outputs 1 time unit later
    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
        axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0; axi.rid = '0; axi.rlast = 1'b1;
        forever begin
            @(posedge aclk);
            if (areset) begin
                got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
                aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
            end else begin
                if (axi.arvalid) cnt_arv++;
                if (axi.awvalid && axi.awready) begin
                    cnt_aw++; got_aw = 1'b1; e_aw = cyc; aw_age = 0;
                    s_awaddr = axi.awaddr;
                    s_awfix = {axi.awid, axi.awlen, axi.awsize, axi.awburst};
                end else if (axi.awvalid) aw_age++;
                if (axi.wvalid && axi.wready) begin
                    cnt_w++; got_w = 1'b1; e_w = cyc; w_age = 0;
                    s_wdata = axi.wdata; s_wstrb = axi.wstrb; s_wlast = axi.wlast;
                end else if (axi.wvalid) w_age++;
                if (axi.bvalid && axi.bready) begin
                    cnt_b++; b_pend = 1'b0; e_b = cyc;
                end
                if (got_aw && got_w) begin
                    s_cur = smem.exists(s_awaddr) ? smem[s_awaddr] : init_word(s_awaddr);
                    for (int b = 0; b < 4; b++) if (s_wstrb[b]) s_cur[8*b +: 8] = s_wdata[8*b +: 8];
                    smem[s_awaddr] = s_cur;
                    got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b1; b_age = 0;
                end else if (b_pend && !axi.bvalid) b_age++;
                if (axi.rvalid && axi.rready) begin
                    cnt_r++; r_pend = 1'b0; e_r = cyc;
                end
                if (axi.arvalid && axi.arready) begin
                    cnt_ar++; e_ar = cyc; ar_age = 0; r_pend = 1'b1; r_age = 0;
                    s_araddr = axi.araddr;
                    s_arfix = {axi.arid, axi.arlen, axi.arsize, axi.arburst};
                    s_rdata = smem.exists(s_araddr) ? smem[s_araddr] : init_word(s_araddr);
                end else begin
                    if (axi.arvalid) ar_age++;
                    if (r_pend && !axi.rvalid) r_age++;
                end
            end
            #1;
            if (areset) begin
                axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
                axi.bvalid = 1'b0; axi.rvalid = 1'b0;
            end else begin
                axi.awready = axi.awvalid && (aw_age >= cfg_aw_delay);
                axi.wready  = axi.wvalid && (w_age >= cfg_w_delay);
                axi.arready = axi.arvalid && !cfg_ar_never && (ar_age >= cfg_ar_delay);
                axi.bvalid  = b_pend && (b_age >= cfg_b_delay);
                axi.bresp   = cfg_resp;
                axi.rvalid  = r_pend && (r_age >= cfg_r_delay);
                axi.rresp   = cfg_resp;
                axi.rdata   = r_pend ? s_rdata : 32'h0;
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int ta);
        int k;
        k = 0;
        @(negedge aclk);
        while (!cmd_ready && k < 200) begin
            @(negedge aclk);
            k++;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        ta = cyc;
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int tr);
        int k;
        k = 0;
        while (!rsp_valid && k < 100) begin
            @(negedge aclk);
            k++;
        end
        check("rsp_wait", rsp_valid, 1'b1);
        tr = cyc;
    endtask

    task automatic take_rsp(input int hold, input logic [31:0] e_rd, input logic [1:0] e_resp,
                            input logic e_tmo);
        check("rsp_rdata", rsp_rdata, e_rd);
        check("rsp_resp", rsp_resp, e_resp);
        check("rsp_timeout", rsp_timeout, e_tmo);
        check("busy_cmd_ready", cmd_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_fields", {rsp_rdata, rsp_resp, rsp_timeout}, {e_rd, e_resp, e_tmo});
            check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 1'b0);
        check("idle_cmd_ready", cmd_ready, 1'b1);
    endtask

    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] resp, input int hold);
        int aw0, w0, b0, ar0, r0;
        logic [31:0] e_rd;
        aw0 = cnt_aw; w0 = cnt_w; b0 = cnt_b; ar0 = cnt_ar; r0 = cnt_r;
        cfg_resp = resp;
        send_cmd(wr, a, d, s, last_ta);
        wait_rsp(last_tr);
        if (wr) begin
            model_write(a, d, s);
            e_rd = 32'h0;
        end else begin
            e_rd = model_read(a);
        end
        take_rsp(hold, e_rd, resp, 1'b0);
        check("aw_beats", cnt_aw - aw0, wr ? 1 : 0);
        check("w_beats", cnt_w - w0, wr ? 1 : 0);
        check("b_beats", cnt_b - b0, wr ? 1 : 0);
        check("ar_beats", cnt_ar - ar0, wr ? 0 : 1);
        check("r_beats", cnt_r - r0, wr ? 0 : 1);
        if (wr) begin
            check("awaddr", s_awaddr, a);
            check("wdata", s_wdata, d);
            check("wstrb", s_wstrb, s);
            check("aw_fixed", {s_awfix, s_wlast}, {1'b0, 8'd0, 3'd2, 2'b01, 1'b1});
        end else begin
            check("araddr", s_araddr, a);
            check("ar_fixed", s_arfix, {1'b0, 8'd0, 3'd2, 2'b01});
        end
    endtask

    initial begin
        int ta, tr, arv0, ar0, r0, b0, seen;
        logic        wr;
        logic [31:0] a, d;

        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_axi_ctrl", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
        check("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 36'h0);
        areset = 1'b0;
        @(negedge aclk);
        check("rst_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait write: AW/W at T+1, B at T+2, response visible at T+3
        do_txn(1'b1, 32'h10, 32'h12345678, 4'hF, 2'b00, 0);
        check("wr_aw_edge", e_aw - last_ta, 1);
        check("wr_w_edge", e_w - last_ta, 1);
        check("wr_b_edge", e_b - last_ta, 2);
        check("wr_rsp_edge", last_tr - last_ta, 3);

        smem[32'h20] = 32'hbaadc0de;
        exp_mem[32'h20] = 32'hbaadc0de;
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 2'b00, 0);
        check("rd_ar_edge", e_ar - last_ta, 1);
        check("rd_r_edge", e_r - last_ta, 2);
        check("rd_rsp_edge", last_tr - last_ta, 3);

        cfg_aw_delay = 0; cfg_w_delay = 3;
        do_txn(1'b1, 32'h14, 32'hcafef00d, 4'b0101, 2'b00, 0);
        check("aw_first_gap", e_w - e_aw, 3);
        cfg_aw_delay = 3; cfg_w_delay = 0;
        do_txn(1'b1, 32'h14, 32'h0badbeef, 4'b1010, 2'b10, 0);
        check("w_first_gap", e_aw - e_w, 3);
        cfg_aw_delay = 0; cfg_w_delay = 0;

        do_txn(1'b0, 32'h14, 32'h0, 4'h0, 2'b00, 5);

        // Read with no arready: aborted after exactly TMO cycles on the bus
        cfg_ar_never = 1'b1;
        arv0 = cnt_arv; ar0 = cnt_ar;
        send_cmd(1'b0, 32'h30, 32'h0, 4'h0, ta);
        wait_rsp(tr);
        check("tmo_rsp_edge", tr - ta, TMO + 1);
        check("tmo_arvalid_cycles", cnt_arv - arv0, TMO);
        check("tmo_arvalid_low", axi.arvalid, 1'b0);
        take_rsp(2, 32'h0, 2'b10, 1'b1);
        check("tmo_no_ar", cnt_ar - ar0, 0);
        cfg_ar_never = 1'b0;

        // R handshake on the very cycle the counter expires wins
        cfg_r_delay = TMO - 2;
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 2'b01, 0);
        check("race_r_edge", e_r - last_ta, TMO);
        check("race_rsp_edge", last_tr - last_ta, TMO + 1);

        // One cycle later the timeout wins and R is left unconsumed
        cfg_r_delay = TMO - 1;
        r0 = cnt_r;
        send_cmd(1'b0, 32'h20, 32'h0, 4'h0, ta);
        wait_rsp(tr);
        check("late_rsp_edge", tr - ta, TMO + 1);
        take_rsp(0, 32'h0, 2'b10, 1'b1);
        repeat (3) @(negedge aclk);
        check("late_r_unconsumed", cnt_r - r0, 0);
        cfg_r_delay = 0;
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;

        // Reset while waiting for B abandons the transaction
        cfg_b_delay = 5;
        b0 = cnt_b;
        send_cmd(1'b1, 32'h400, 32'h55aa55aa, 4'hF, ta);
        @(negedge aclk);
        check("wb_bready", axi.bready, 1'b1);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        check("rst_wb_ctrl", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
        check("rst_wb_rsp_valid", rsp_valid, 1'b0);
        check("rst_wb_cmd_ready", cmd_ready, 1'b1);
        seen = 0;
        repeat (8) begin
            @(negedge aclk);
            if (rsp_valid) seen++;
        end
        check("rst_wb_no_rsp", seen, 0);
        check("rst_wb_no_b", cnt_b - b0, 0);
        cfg_b_delay = 0;

        for (int k = 0; k < 24; k++) begin
            cfg_aw_delay = $urandom_range(0, 3);
            cfg_w_delay  = $urandom_range(0, 3);
            cfg_ar_delay = $urandom_range(0, 3);
            cfg_b_delay  = $urandom_range(0, 3);
            cfg_r_delay  = $urandom_range(0, 3);
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 7)) << 2;
            d  = $urandom;
            do_txn(wr, a, d, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
